serial_tx: RTL

- Parallel-in, serial-out transmitter; the stage directly upstream of the run-of-ones detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first on ostream, one bit per rising clk edge.
- ostream connects directly to the detector's istream.
- Idle line level is 0, which keeps the downstream run counter cleared between frames.

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_stuff_ctr.sv | 33 +++
 rtl/serial_tx.sv | 85 ++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state type, default sizes and counter-width helper for serial_tx
package serial_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int SERIAL_WIDTH   = 17;
    localparam int SERIAL_RUN_MAX = 4;

    // Smallest r such that 2**r >= v; sizes counters that must hold the value v-1.
    function automatic int serial_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_stuff_ctr.sv
// serial_stuff_ctr: counts consecutive driven 1s and flags when a stuffed 0 must follow
module serial_stuff_ctr
    import serial_pkg::*;
#(
    parameter int RUN_MAX = SERIAL_RUN_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_out,
    input  logic valid,
    input  logic clear,
    output logic stuff_now
);

    localparam int RW = serial_clog2(RUN_MAX + 1);

    logic [RW-1:0] run_q, run_d;

    // Any driven 0 (data, stuffed or idle) breaks the run; a driven 1 extends it.
    always_comb begin
        run_d = (clear || !valid || !bit_out) ? '0 : run_q + 1'b1;
    end

    // The bit on the line now completes a run of RUN_MAX ones, so the next cycle must be a stuffed 0.
    assign stuff_now = valid && bit_out && (run_q == RW'(RUN_MAX - 1));

    // Run length register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= '0;
        else        run_q <= run_d;
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, MSB-first serial-out transmitter with valid/ready input.
// Optional bit stuffing after RUN_MAX consecutive 1s is enabled with SERIAL_STUFF_EN.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH   = SERIAL_WIDTH,
    parameter int RUN_MAX = SERIAL_RUN_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ostream,
    output logic             ostream_valid,
    output logic             busy
);

    localparam int CW = serial_clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             stuff_q, stuff_d;
    logic             stuff_now;
    logic             last_bit;

    assign busy          = (state_q == SHIFT);
    assign ostream_valid = busy;
    assign ostream       = busy && !stuff_q && sh_q[WIDTH-1];
    assign last_bit      = busy && !stuff_q && (cnt_q == CW'(WIDTH));
    assign din_ready     = !busy || (last_bit && !stuff_now);

`ifdef SERIAL_STUFF_EN
    serial_stuff_ctr #(.RUN_MAX(RUN_MAX)) u_stuff (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_out   (ostream),
        .valid     (ostream_valid),
        .clear     (!busy),
        .stuff_now (stuff_now)
    );
`else
    assign stuff_now = 1'b0 && (RUN_MAX > 0);
`endif

    // Next state: load on accept, hold through a stuffed 0, otherwise shift until bit 0 has been shown.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        stuff_d = 1'b0;
        if (din_valid && din_ready) begin
            state_d = SHIFT;
            sh_d    = din;
            cnt_d   = CW'(1);
        end else if (busy) begin
            if (stuff_now) begin
                stuff_d = 1'b1;
            end else if (cnt_q == CW'(WIDTH)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, shifter, bit counter and stuff flag registers; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            stuff_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            stuff_q <= stuff_d;
        end
    end

endmodule
